// File: rtl/dram_pkg.sv
// Shared encodings and defaults for the DRAM block-transfer port model.
package dram_pkg;

    localparam int DRAM_DEFAULT_W = 512;

    localparam logic [1:0] DRAM_REQ_NONE  = 2'd0;
    localparam logic [1:0] DRAM_REQ_WRITE = 2'd1;
    localparam logic [1:0] DRAM_REQ_READ  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } dram_state_e;

endpackage

// File: rtl/dram_rd_pipe.sv
// RD_LAT-stage valid+data shift register carrying read data to the port.
module dram_rd_pipe #(
    parameter int DRAMW  = 512,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             in_vld,
    input  logic [DRAMW-1:0] in_data,
    output logic             out_vld,
    output logic [DRAMW-1:0] out_data,
    output logic             empty
);

    logic [RD_LAT-1:0] vld_q;
    logic [DRAMW-1:0]  dat_q [RD_LAT];

    // Data only moves with its valid, so the output stage holds its last value.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    // Empty once nothing remains behind the output stage: the pipe is clear after this edge.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (vld_q[i]) begin
                empty = 1'b0;
            end
        end
    end

    assign out_vld  = vld_q[RD_LAT-1];
    assign out_data = dat_q[RD_LAT-1];

endmodule

// File: rtl/dram_blk_model.sv
// Cycle-accurate behavioural model of the DRAM block-transfer port: burst
// writes/reads with programmable read latency, stall injection and sticky error.
module dram_blk_model
  import dram_pkg::*;
#(
  parameter int    DRAMW        = DRAM_DEFAULT_W,
  parameter int    DEPTH        = 1 << 20,
  parameter int    STEP         = 8,
  parameter int    RD_LAT       = 1,
  parameter int    STALL_PERIOD = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic [1:0]       D_REQ,
  input  logic [31:0]      D_INITADR,
  input  logic [31:0]      D_ELEM,
  input  logic [DRAMW-1:0] D_DIN,
  output logic             D_W,
  output logic [DRAMW-1:0] D_DOUT,
  output logic             D_DOUTEN,
  output logic             D_BUSY,
  output logic             D_ERR
);

  localparam int          SHIFT      = $clog2(STEP);
  localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ALIGN_MASK = 32'(STEP - 1);

  if (STALL_PERIOD == 1) begin : g_bad_stall
    $error("dram_blk_model: STALL_PERIOD=1 would stall every cycle");
  end
  if (RD_LAT < 1 || RD_LAT > 16) begin : g_bad_lat
    $error("dram_blk_model: RD_LAT must be within 1..16");
  end

  dram_state_e      state;
  logic [31:0]      addr;
  logic [31:0]      remain;
  logic [31:0]      stall_cnt;
  logic             rdy;
  logic [IDX_W-1:0] idx;
  logic [31:0]      next_addr;
  logic             issue;
  logic             pipe_empty;
  logic [DRAMW-1:0] mem [DEPTH];

  assign rdy       = (STALL_PERIOD == 0) || (stall_cnt != 32'(STALL_PERIOD - 1));
  assign idx       = IDX_W'((addr >> SHIFT) % 32'(DEPTH));
  assign next_addr = (idx == IDX_W'(DEPTH - 1)) ? '0 : addr + 32'(STEP);
  assign D_W       = (state == ST_WRITE) && rdy;
  assign issue     = (state == ST_READ) && rdy;
  assign D_BUSY    = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remain    <= '0;
      stall_cnt <= '0;
      D_ERR     <= 1'b0;
    end else begin
      if (STALL_PERIOD == 0 || stall_cnt == 32'(STALL_PERIOD - 1)) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      case (state)
        ST_IDLE: begin
          if (D_REQ == DRAM_REQ_WRITE || D_REQ == DRAM_REQ_READ) begin
            if (D_ELEM == '0) begin
              D_ERR <= 1'b1;
            end else begin
              if (|(D_INITADR & ALIGN_MASK)) begin
                D_ERR <= 1'b1;
              end
              addr   <= D_INITADR & ~ALIGN_MASK;
              remain <= D_ELEM;
              state  <= (D_REQ == DRAM_REQ_WRITE) ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE, ST_READ: begin
          if (rdy) begin
            addr   <= next_addr;
            remain <= remain - 32'd1;
            if (remain == 32'd1) begin
              state <= (state == ST_WRITE) ? ST_IDLE : ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (D_W) begin
      mem[idx] <= D_DIN;
    end
  end

  dram_rd_pipe #(
    .DRAMW  (DRAMW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .CLK      (CLK),
    .RST_X    (RST_X),
    .in_vld   (issue),
    .in_data  (mem[idx]),
    .out_vld  (D_DOUTEN),
    .out_data (D_DOUT),
    .empty    (pipe_empty)
  );

endmodule
